// File: rtl/ps2_rx_sequencer.sv
// ps2_rx_sequencer
//   Receives PS/2 keyboard frames into the clk domain. The ps2_clk and
//   ps2_data lines pass through synchronisers. An FSM runs on falling edges
//   of the synchronised ps2_clk and checks the start bit, odd parity and stop
//   bit of each 11-bit frame. An inter-bit timeout abandons stalled frames.
//   Good bytes are presented on a valid/ready output. The BAT-complete code
//   0xAA raises a sticky reset request.
//
//   Optional build macro PS2_RX_FIFO_EN: the single holding register is
//   replaced by a FIFO_DEPTH-entry first-word-fall-through FIFO.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   ps2_clk/ps2_data  keyboard lines (asynchronous to clk)
//   rx_data/rx_valid  received byte and its valid flag
//   rx_ready          consumer ready
//   frame_err         1-cycle pulse: start/parity/stop error or timeout
//   overflow          1-cycle pulse: completed byte dropped, no room for it
//   reset_required    sticky, set when 0xAA is stored, cleared by reset_ack
//   reset_ack         clears reset_required
//   busy              FSM is not IDLE (exposes the frame-in-progress state)
//
// Handshake: a byte moves on every clk edge where rx_valid && rx_ready.
// While rx_valid is high and rx_ready is low, rx_data is held stable.
// rx_valid only drops after its byte has been accepted.
module ps2_rx_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 5000
`ifdef PS2_RX_FIFO_EN
  , parameter int FIFO_DEPTH   = 4
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       reset_required,
  input  logic       reset_ack,
  output logic       busy
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // The counter is cleared on the edge that registers a fall. Firing one
  // count early makes frame_err appear TIMEOUT_CYCLES-1 cycles after that
  // edge.
  localparam logic [TW-1:0] TO_FIRE = TW'(TIMEOUT_CYCLES - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   clk_s, data_s, fall;

  logic [1:0]    state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          timeout, parity_ok, deliver, frame_err_c, store;

  // Synchronisers idle high, matching an idle PS/2 bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign data_s = data_sync[SYNC_STAGES-1];
  assign fall   = clk_prev & ~clk_s;

  assign parity_ok   = ^{shreg, par_bit};
  assign timeout     = (state != S_IDLE) && !fall && (tcnt == TO_FIRE);
  assign deliver     = fall && (state == S_STOP) && data_s && parity_ok;
  assign frame_err_c = timeout
                     | (fall && (state == S_IDLE) && data_s)
                     | (fall && (state == S_STOP) && !(data_s && parity_ok));
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      bit_cnt   <= 3'd0;
      shreg     <= 8'h00;
      par_bit   <= 1'b0;
      tcnt      <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= frame_err_c;
      if (state == S_IDLE || fall) tcnt <= '0;
      else                         tcnt <= tcnt + 1'b1;

      if (timeout) begin
        state   <= S_IDLE;
        bit_cnt <= 3'd0;
      end else if (fall) begin
        case (state)
          S_IDLE: begin
            if (!data_s) begin
              state   <= S_DATA;
              bit_cnt <= 3'd0;
            end
          end
          S_DATA: begin
            shreg <= {data_s, shreg[7:1]};
            if (bit_cnt == 3'd7) state   <= S_PARITY;
            else                 bit_cnt <= bit_cnt + 3'd1;
          end
          S_PARITY: begin
            par_bit <= data_s;
            state   <= S_STOP;
          end
          default: begin
            state   <= S_IDLE;
            bit_cnt <= 3'd0;
          end
        endcase
      end
    end
  end

`ifdef PS2_RX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          full, rd;

  assign full     = (count == FULL_CNT);
  assign rx_valid = (count != '0);
  assign rd       = rx_valid && rx_ready;
  // A read in the same cycle frees the slot, so a write when full succeeds.
  assign store    = deliver && (!full || rd);
  assign rx_data  = rx_valid ? mem[rd_ptr] : 8'h00;

  always_ff @(posedge clk) begin
    if (store) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= deliver && !store;
      if (store) wr_ptr <= wr_ptr + 1'b1;
      if (rd)    rd_ptr <= rd_ptr + 1'b1;
      case ({store, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
`else
  // The slot takes a new byte if it is empty or being emptied this cycle.
  assign store = deliver && (!rx_valid || rx_ready);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= deliver && !store;
      if (store) begin
        rx_data  <= shreg;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end
`endif

  // A set in the same cycle as reset_ack takes priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          reset_required <= 1'b0;
    else if (store && shreg == 8'hAA) reset_required <= 1'b1;
    else if (reset_ack)               reset_required <= 1'b0;
  end

endmodule
